// File: rtl/fetch_pkg.sv
// Shared constants and the redirect decode enum for the instruction-fetch front end.
// Optional stack occupancy flags are controlled by the STACK_FLAGS_EN macro (see call_stack).
package fetch_pkg;

  localparam int PC_W       = 13;
  localparam int INSTR_W    = 14;
  localparam int TARGET_W   = 11;
  localparam int STACK_LOG2 = 3;

  localparam logic [INSTR_W-1:0] NOP_WORD = 14'h0000;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_SEQ,
    RD_JUMP,
    RD_CALL,
    RD_RET,
    RD_SKIP
  } redirect_t;

endpackage

// File: rtl/fetch_stage_call_stack.sv
// Circular hardware call/return stack; the pointer wraps, so a ninth push overwrites the oldest entry.
// With STACK_FLAGS_EN defined, a saturating occupancy counter drives sticky overflow/underflow flags.
module call_stack
  import fetch_pkg::*;
#(
  parameter int DATA_W     = PC_W,
  parameter int DEPTH_LOG2 = STACK_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_W-1:0]     push_data,
  output logic [DATA_W-1:0]     top_data,
  output logic [DEPTH_LOG2-1:0] ptr,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_W-1:0] entries [2**DEPTH_LOG2];

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (push) begin
      ptr <= ptr + DEPTH_LOG2'(1);
    end else if (pop) begin
      ptr <= ptr - DEPTH_LOG2'(1);
    end
  end

  assign top_data = entries[ptr - DEPTH_LOG2'(1)];

`ifdef STACK_FLAGS_EN
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(2**DEPTH_LOG2);

  logic [CNT_W-1:0] count;

  // Count saturates at empty/full while the pointer keeps wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      if (count == FULL) begin
        overflow <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (pop) begin
      if (count == '0) begin
        underflow <= 1'b1;
      end else begin
        count <= count - CNT_W'(1);
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC and call stack, drives the 1-cycle synchronous instruction
// memory and inserts a NOP bubble on redirects. Optional feature macro: STACK_FLAGS_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH         = PC_W,
  parameter int INSTR_WIDTH      = INSTR_W,
  parameter int TARGET_WIDTH     = TARGET_W,
  parameter int STACK_DEPTH_LOG2 = STACK_LOG2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        jump_valid,
  input  logic                        jump_is_call,
  input  logic [TARGET_WIDTH-1:0]     jump_target,
  input  logic                        ret_valid,
  input  logic                        skip,
  output logic [PC_WIDTH-1:0]         imem_addr,
  output logic                        imem_en,
  input  logic [INSTR_WIDTH-1:0]      imem_data,
  output logic [INSTR_WIDTH-1:0]      instr,
  output logic                        instr_valid,
  output logic [PC_WIDTH-1:0]         instr_pc,
  output logic [STACK_DEPTH_LOG2-1:0] stack_ptr,
  output logic                        stack_overflow,
  output logic                        stack_underflow
);

  redirect_t           redirect;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] stack_top;
  logic                push;
  logic                pop;

  // Fixed priority: stall > return > jump/call > skip > sequential.
  always_comb begin
    redirect = RD_NONE;
    if (stall) begin
      redirect = RD_NONE;
    end else if (ret_valid) begin
      redirect = RD_RET;
    end else if (jump_valid) begin
      redirect = jump_is_call ? RD_CALL : RD_JUMP;
    end else if (skip) begin
      redirect = RD_SKIP;
    end else begin
      redirect = RD_SEQ;
    end
  end

  always_comb begin
    pc_next = pc;
    case (redirect)
      RD_SEQ, RD_SKIP:  pc_next = pc + PC_WIDTH'(1);
      RD_JUMP, RD_CALL: pc_next = PC_WIDTH'(jump_target);
      RD_RET:           pc_next = stack_top;
      default:          pc_next = pc;
    endcase
  end

  // pc is the address in flight, so it is also the return address pushed by a call.
  assign push = (redirect == RD_CALL);
  assign pop  = (redirect == RD_RET);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect != RD_NONE) begin
      pc          <= pc_next;
      instr_pc    <= pc;
      instr_valid <= (redirect == RD_SEQ);
    end
  end

  assign imem_addr = pc;
  assign imem_en   = ~stall;
  assign instr     = instr_valid ? imem_data : INSTR_WIDTH'(NOP_WORD);

  call_stack #(
    .DATA_W     (PC_WIDTH),
    .DEPTH_LOG2 (STACK_DEPTH_LOG2)
  ) u_call_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc),
    .top_data  (stack_top),
    .ptr       (stack_ptr),
    .overflow  (stack_overflow),
    .underflow (stack_underflow)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random redirects against
// an instruction-stream reference model; flag expectations follow STACK_FLAGS_EN.
module tb_fetch_stage;

`ifdef STACK_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump_valid;
  logic        jump_is_call;
  logic [10:0] jump_target;
  logic        ret_valid;
  logic        skip;
  logic [12:0] imem_addr;
  logic        imem_en;
  logic [13:0] imem_data;
  logic [13:0] instr;
  logic        instr_valid;
  logic [12:0] instr_pc;
  logic [2:0]  stack_ptr;
  logic        stack_overflow;
  logic        stack_underflow;

  logic [13:0] mem [8192];

  int compared   = 0;
  int mismatched = 0;

  // Reference model: what the decoder sees, the next fetch address, and the return stack.
  int m_fetch;
  int m_cur_pc;
  bit m_valid;
  int m_stk [8];
  int m_sp;
  int m_count;
  bit m_ovf;
  bit m_unf;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_en) imem_data <= mem[imem_addr];
  end

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .jump_valid      (jump_valid),
    .jump_is_call    (jump_is_call),
    .jump_target     (jump_target),
    .ret_valid       (ret_valid),
    .skip            (skip),
    .imem_addr       (imem_addr),
    .imem_en         (imem_en),
    .imem_data       (imem_data),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_pc        (instr_pc),
    .stack_ptr       (stack_ptr),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch  = 0;
    m_cur_pc = 0;
    m_valid  = 1'b0;
    m_sp     = 0;
    m_count  = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic model_update();
    if (stall) begin
      // nothing advances
    end else if (ret_valid) begin
      m_sp     = (m_sp + 7) % 8;
      m_cur_pc = m_fetch;
      m_fetch  = m_stk[m_sp];
      m_valid  = 1'b0;
      if (m_count == 0) m_unf = 1'b1;
      else m_count--;
    end else if (jump_valid) begin
      if (jump_is_call) begin
        m_stk[m_sp] = m_fetch;
        m_sp        = (m_sp + 1) % 8;
        if (m_count == 8) m_ovf = 1'b1;
        else m_count++;
      end
      m_cur_pc = m_fetch;
      m_fetch  = int'(jump_target);
      m_valid  = 1'b0;
    end else begin
      m_cur_pc = m_fetch;
      m_fetch  = (m_fetch + 1) % 8192;
      m_valid  = !skip;
    end
  endtask

  task automatic check_output();
    logic [13:0] exp_instr;
    exp_instr = m_valid ? mem[m_cur_pc] : 14'h0000;
    check_val("instr_valid", 32'(instr_valid), 32'(m_valid));
    check_val("instr", 32'(instr), 32'(exp_instr));
    if (m_valid) check_val("instr_pc", 32'(instr_pc), 32'(m_cur_pc));
    check_val("imem_addr", 32'(imem_addr), 32'(m_fetch));
    check_val("imem_en", 32'(imem_en), 32'(!stall));
    check_val("stack_ptr", 32'(stack_ptr), 32'(m_sp));
    check_val("stack_overflow", 32'(stack_overflow), 32'(FLAGS_EN & m_ovf));
    check_val("stack_underflow", 32'(stack_underflow), 32'(FLAGS_EN & m_unf));
  endtask

  task automatic apply_stimulus(input bit st, input bit rv, input bit jv, input bit jc,
                                input int tgt, input bit sk);
    stall        = st;
    ret_valid    = rv;
    jump_valid   = jv;
    jump_is_call = jc;
    jump_target  = 11'(tgt);
    skip         = sk;
    @(posedge clk);
    model_update();
    #1;
    check_output();
  endtask

  task automatic seq();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    stall = 1'b0; ret_valid = 1'b0; jump_valid = 1'b0;
    jump_is_call = 1'b0; jump_target = '0; skip = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_output();
    @(posedge clk);
    #1;
    check_output();
    reset = 1'b1;
  endtask

  initial begin
    int saved_pc;
    stall = 1'b0; ret_valid = 1'b0; jump_valid = 1'b0;
    jump_is_call = 1'b0; jump_target = '0; skip = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 8192; i++) mem[i] = 14'($urandom);
    mem[0] = 14'h3001; mem[1] = 14'h3002; mem[2] = 14'h3003; mem[3] = 14'h3004;
    for (int i = 0; i < 8; i++) m_stk[i] = -1;
    $display("[TB] start, STACK_FLAGS_EN=%0d", FLAGS_EN);
    #2;
    do_reset();

    seq(); check_val("first_instr", 32'(instr), 32'h3001); check_val("first_pc", 32'(instr_pc), 0);
    seq(); check_val("second_instr", 32'(instr), 32'h3002); check_val("second_pc", 32'(instr_pc), 1);
    seq(); check_val("third_instr", 32'(instr), 32'h3003); check_val("third_addr", 32'(imem_addr), 3);

    for (int i = 0; i < 20 && !(m_valid && m_cur_pc == 5); i++) seq();
    check_val("reach_pc5", 32'(instr_pc), 5);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 'h100, 1'b0);
    check_val("call_bubble", 32'(instr_valid), 0);
    seq();
    check_val("call_target_pc", 32'(instr_pc), 'h100);
    check_val("call_target_instr", 32'(instr), 32'(mem['h100]));
    check_val("call_sp", 32'(stack_ptr), 1);

    for (int i = 0; i < 20 && !(m_valid && m_cur_pc == 'h102); i++) seq();
    check_val("reach_pc102", 32'(instr_pc), 'h102);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_val("ret_bubble", 32'(instr_valid), 0);
    seq();
    check_val("ret_pc", 32'(instr_pc), 6);
    check_val("ret_sp", 32'(stack_ptr), 0);

    for (int i = 0; i < 20 && !(m_valid && m_cur_pc == 9); i++) seq();
    check_val("reach_pc9", 32'(instr_pc), 9);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    check_val("skip_bubble", 32'(instr_valid), 0);
    seq();
    check_val("skip_next_pc", 32'(instr_pc), 11);

    saved_pc = int'(instr_pc);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 'h55, 1'b1);
      check_val("stall_hold_pc", 32'(instr_pc), 32'(saved_pc));
    end
    seq();
    check_val("stall_resume_pc", 32'(instr_pc), 32'(saved_pc + 1));

    do_reset();
    for (int i = 0; i < 9; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 16 * (i + 1), 1'b0);
    check_val("nine_calls_sp", 32'(stack_ptr), 1);
    check_val("nine_calls_ovf", 32'(stack_overflow), 32'(FLAGS_EN));
    seq();
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    check_val("empty_pop_sp", 32'(stack_ptr), 7);
    check_val("empty_pop_unf", 32'(stack_underflow), 32'(FLAGS_EN));
    seq();

    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 6,
                     $urandom_range(0, 99) < 10, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 2047)), $urandom_range(0, 99) < 10);
    end

    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 'h7FF, 1'b0);
    for (int i = 0; i < 8000 && !(m_valid && m_cur_pc == 'h1FFF); i++) seq();
    check_val("reach_top_pc", 32'(instr_pc), 'h1FFF);
    check_val("wrap_addr", 32'(imem_addr), 0);
    seq();
    check_val("wrap_pc", 32'(instr_pc), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
